// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// Holds the register/data types and the request bundle stored in the FIFO.
package wb_pkg;

    typedef logic [4:0]  regf_t;
    typedef logic [31:0] data_t;

    typedef struct packed {
        regf_t regf;
        data_t data;
    } wb_req_t;

    localparam regf_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t used to buffer long-latency results.
// Ports: push/din in, full out, pop in, empty out, head out; async active-low reset.
import wb_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t din,
    output logic    full,
    input  logic    pop,
    output logic    empty,
    output wb_req_t head
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB is the wrap bit separating full from empty.
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    wb_req_t       r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_wr == r_rd);
    assign full   = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results into one GPR write.
// Ports: pipe_*, lng_*, iss_* in; busy, stall_req, rd_regf, rd_data out; rst async active-low.
// Optional WB_BYPASS_EN adds rs/rt read-port forwarding from the rd register.
import wb_pkg::*;

module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  regf_t       pipe_regf,
    input  data_t       pipe_data,
    input  logic        lng_valid,
    output logic        lng_ready,
    input  regf_t       lng_regf,
    input  data_t       lng_data,
    input  logic        iss_valid,
    input  regf_t       iss_regf,
    output logic [31:0] busy,
`ifdef WB_BYPASS_EN
    input  regf_t       rs_regf,
    input  regf_t       rt_regf,
    input  data_t       gpr_rs_data,
    input  data_t       gpr_rt_data,
    output data_t       rs_data,
    output data_t       rt_data,
`endif
    output logic        stall_req,
    output regf_t       rd_regf,
    output data_t       rd_data
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    regf_t       r_rd_regf;
    data_t       r_rd_data;
    logic        r_rd_fifo;
    logic [31:0] r_busy;
    logic [CW-1:0] r_cnt;
    logic        r_stall;

    logic        w_full;
    logic        w_empty;
    wb_req_t     w_head;
    wb_req_t     w_din;
    logic        w_push;
    logic        w_pop;
    logic        w_pipe_wr;
    logic        w_clr_en;
    logic [31:0] w_busy_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign lng_ready = !w_full;
    assign w_pipe_wr = pipe_valid && (pipe_regf != REG_ZERO);
    // Zero-destination results complete the handshake but are dropped.
    assign w_push    = lng_valid && lng_ready && (lng_regf != REG_ZERO);
    assign w_pop     = !w_pipe_wr && !w_empty;
    assign w_din     = '{regf: lng_regf, data: lng_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_push),
        .din   (w_din),
        .full  (w_full),
        .pop   (w_pop),
        .empty (w_empty),
        .head  (w_head)
    );

    // A FIFO-sourced write sitting in rd commits this edge.
    assign w_clr_en = r_rd_fifo && (r_rd_regf != REG_ZERO);

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr_en)
            w_busy_nxt[r_rd_regf] = 1'b0;
        if (iss_valid && (iss_regf != REG_ZERO))
            w_busy_nxt[iss_regf] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_empty || w_pop)
            w_cnt_nxt = '0;
        else if (r_cnt < CW'(STARVE_MAX))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_regf <= REG_ZERO;
            r_rd_data <= '0;
            r_rd_fifo <= 1'b0;
            r_busy    <= '0;
            r_cnt     <= '0;
            r_stall   <= 1'b0;
        end else begin
            unique case (1'b1)
                w_pipe_wr: begin
                    r_rd_regf <= pipe_regf;
                    r_rd_data <= pipe_data;
                    r_rd_fifo <= 1'b0;
                end
                w_pop: begin
                    r_rd_regf <= w_head.regf;
                    r_rd_data <= w_head.data;
                    r_rd_fifo <= 1'b1;
                end
                default: begin
                    r_rd_regf <= REG_ZERO;
                    r_rd_data <= '0;
                    r_rd_fifo <= 1'b0;
                end
            endcase
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stall <= (w_cnt_nxt >= CW'(STARVE_MAX));
        end
    end

    assign busy      = r_busy;
    assign stall_req = r_stall;
    assign rd_regf   = r_rd_regf;
    assign rd_data   = r_rd_data;

`ifdef WB_BYPASS_EN
    assign rs_data = (rs_regf == r_rd_regf && r_rd_regf != REG_ZERO) ?
                     r_rd_data : gpr_rs_data;
    assign rt_data = (rt_regf == r_rd_regf && r_rd_regf != REG_ZERO) ?
                     r_rd_data : gpr_rt_data;
`endif

`ifndef SYNTHESIS
    // Re-issue is only legal when the old write commits on this same edge.
    always @(posedge clk) begin
        if (rst && iss_valid && (iss_regf != REG_ZERO))
            assert (!r_busy[iss_regf] ||
                    (w_clr_en && r_rd_regf == iss_regf))
            else $error("wb_arbiter: issue to busy register %0d", iss_regf);
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
// Checks reset, priority, FIFO ordering, scoreboard, starvation and reset abort.
import wb_pkg::*;

module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    regf_t       pipe_regf;
    data_t       pipe_data;
    logic        lng_valid;
    logic        lng_ready;
    regf_t       lng_regf;
    data_t       lng_data;
    logic        iss_valid;
    regf_t       iss_regf;
    logic [31:0] busy;
    logic        stall_req;
    regf_t       rd_regf;
    data_t       rd_data;
`ifdef WB_BYPASS_EN
    regf_t       rs_regf;
    regf_t       rt_regf;
    data_t       gpr_rs_data;
    data_t       gpr_rt_data;
    data_t       rs_data;
    data_t       rt_data;
`endif

    int checks;
    int failures;

    wb_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_regf  (pipe_regf),
        .pipe_data  (pipe_data),
        .lng_valid  (lng_valid),
        .lng_ready  (lng_ready),
        .lng_regf   (lng_regf),
        .lng_data   (lng_data),
        .iss_valid  (iss_valid),
        .iss_regf   (iss_regf),
        .busy       (busy),
`ifdef WB_BYPASS_EN
        .rs_regf     (rs_regf),
        .rt_regf     (rt_regf),
        .gpr_rs_data (gpr_rs_data),
        .gpr_rt_data (gpr_rt_data),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
`endif
        .stall_req  (stall_req),
        .rd_regf    (rd_regf),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] r,
                          input logic [31:0] d);
        chk({tag, "_regf"}, 32'(rd_regf), 32'(r));
        chk({tag, "_data"}, rd_data, d);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        pipe_valid = 1'b0;
        pipe_regf  = '0;
        pipe_data  = '0;
        lng_valid  = 1'b0;
        lng_regf   = '0;
        lng_data   = '0;
        iss_valid  = 1'b0;
        iss_regf   = '0;
`ifdef WB_BYPASS_EN
        rs_regf     = '0;
        rt_regf     = '0;
        gpr_rs_data = '0;
        gpr_rt_data = '0;
`endif
        #1;
        chk_rd("reset_rd", 5'd0, 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_ready", 32'(lng_ready), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: pipeline write, one-cycle hold then clear
        pipe_valid = 1'b1;
        pipe_regf  = 5'd5;
        pipe_data  = 32'hDEADBEEF;
        tick();
        pipe_valid = 1'b0;
        chk_rd("t1_pipe", 5'd5, 32'hDEADBEEF);
        tick();
        chk_rd("t1_idle", 5'd0, 32'h0);

        // 2: issue, long result, scoreboard clear
        iss_valid = 1'b1;
        iss_regf  = 5'd9;
        tick();
        iss_valid = 1'b0;
        chk("t2_busy_set", busy, 32'h0000_0200);
        tick();
        chk("t2_busy_hold", busy, 32'h0000_0200);
        lng_valid = 1'b1;
        lng_regf  = 5'd9;
        lng_data  = 32'h1234;
        chk("t2_ready", 32'(lng_ready), 32'd1);
        tick();
        lng_valid = 1'b0;
        chk_rd("t2_no_bypass", 5'd0, 32'h0);
        tick();
        chk_rd("t2_long", 5'd9, 32'h1234);
        chk("t2_busy_until_commit", busy, 32'h0000_0200);
        tick();
        chk("t2_busy_clr", busy, 32'h0);
        chk_rd("t2_idle", 5'd0, 32'h0);

        // 3: fill FIFO under pipe pressure, starvation, ordered drain
        pipe_valid = 1'b1;
        pipe_regf  = 5'd1;
        pipe_data  = 32'h11;
        for (int i = 0; i < 4; i++) begin
            lng_valid = 1'b1;
            lng_regf  = 5'(10 + i);
            lng_data  = 32'hA0 + 32'(i);
            tick();
        end
        chk("t3_full", 32'(lng_ready), 32'd0);
        chk_rd("t3_pipe_wins", 5'd1, 32'h11);
        lng_regf = 5'd14;
        lng_data = 32'hA4;
        for (int i = 0; i < 4; i++)
            tick();
        chk("t3_no_stall_7", 32'(stall_req), 32'd0);
        tick();
        chk("t3_stall_8", 32'(stall_req), 32'd1);
        chk("t3_still_full", 32'(lng_ready), 32'd0);
        pipe_valid = 1'b0;
        tick();
        chk_rd("t3_drain0", 5'd10, 32'hA0);
        chk("t3_stall_clr", 32'(stall_req), 32'd0);
        chk("t3_ready_again", 32'(lng_ready), 32'd1);
        tick();
        lng_valid = 1'b0;
        chk_rd("t3_drain1", 5'd11, 32'hA1);
        tick();
        chk_rd("t3_drain2", 5'd12, 32'hA2);
        tick();
        chk_rd("t3_drain3", 5'd13, 32'hA3);
        tick();
        chk_rd("t3_drain4", 5'd14, 32'hA4);
        tick();
        chk_rd("t3_empty", 5'd0, 32'h0);

        // 4: same-edge set and clear of reg 3; zero-dest long result
        iss_valid = 1'b1;
        iss_regf  = 5'd3;
        tick();
        iss_valid = 1'b0;
        chk("t4_busy_set", busy, 32'h0000_0008);
        lng_valid = 1'b1;
        lng_regf  = 5'd3;
        lng_data  = 32'h33;
        tick();
        lng_valid = 1'b0;
        tick();
        chk_rd("t4_long", 5'd3, 32'h33);
        iss_valid = 1'b1;
        iss_regf  = 5'd3;
        tick();
        iss_valid = 1'b0;
        chk("t4_set_wins", busy, 32'h0000_0008);
        pipe_valid = 1'b1;
        pipe_regf  = 5'd2;
        pipe_data  = 32'h22;
        lng_valid  = 1'b1;
        lng_regf   = 5'd0;
        lng_data   = 32'hFF;
        tick();
        pipe_valid = 1'b0;
        lng_valid  = 1'b0;
        chk("t4_zero_ready", 32'(lng_ready), 32'd1);
        chk_rd("t4_pipe", 5'd2, 32'h22);
        tick();
        chk_rd("t4_zero_nowrite", 5'd0, 32'h0);
        chk("t4_zero_busy", busy, 32'h0000_0008);

        // 5: reset while FIFO holds 3 entries
        pipe_valid = 1'b1;
        pipe_regf  = 5'd4;
        pipe_data  = 32'h44;
        iss_valid  = 1'b1;
        iss_regf   = 5'd20;
        for (int i = 0; i < 3; i++) begin
            lng_valid = 1'b1;
            lng_regf  = 5'(21 + i);
            lng_data  = 32'hB0 + 32'(i);
            tick();
            iss_valid = 1'b0;
        end
        lng_valid = 1'b0;
        chk("t5_busy_pre", busy, 32'h0010_0008);
        chk("t5_ready_pre", 32'(lng_ready), 32'd1);
        #2;
        rst        = 1'b0;
        pipe_valid = 1'b0;
        #1;
        chk_rd("t5_rst_rd", 5'd0, 32'h0);
        chk("t5_rst_busy", busy, 32'h0);
        chk("t5_rst_ready", 32'(lng_ready), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk_rd("t5_post0", 5'd0, 32'h0);
        tick();
        chk_rd("t5_post1", 5'd0, 32'h0);
        chk("t5_post_busy", busy, 32'h0);

`ifdef WB_BYPASS_EN
        // 6: forwarding from rd
        pipe_valid = 1'b1;
        pipe_regf  = 5'd7;
        pipe_data  = 32'hA5A5A5A5;
        tick();
        pipe_valid  = 1'b0;
        rs_regf     = 5'd7;
        gpr_rs_data = 32'h0;
        rt_regf     = 5'd8;
        gpr_rt_data = 32'h0BAD_F00D;
        #1;
        chk("t6_rs_fwd", rs_data, 32'hA5A5A5A5);
        chk("t6_rt_pass", rt_data, 32'h0BAD_F00D);
        rs_regf     = 5'd0;
        gpr_rs_data = 32'h5555;
        #1;
        chk("t6_rs_zero", rs_data, 32'h5555);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
